imm_extend_unit: RTL and testbench

IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

---
 rtl/imm_extend_unit_pkg.sv | 19 +
 rtl/imm_extend_core.sv | 33 +++
 rtl/imm_extend_unit.sv | 90 +++++++++
 tb/tb_imm_extend_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/imm_extend_unit_pkg.sv
// Shared constants for the immediate extension unit.
// The decoder and the control logic both use these names for mode and state encodings.
package imm_extend_unit_pkg;

  // Immediate extension modes, as carried on in_mode.
  typedef enum logic [1:0] {
    MODE_SEXT      = 2'b00,
    MODE_ZEXT      = 2'b01,
    MODE_SEXT_SHL1 = 2'b10,
    MODE_CONCAT    = 2'b11
  } mode_e;

  // Control states: IDLE, or holding the upper beat of a CONCAT pair.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HI_HELD = 1'b1
  } state_e;

endpackage : imm_extend_unit_pkg

// File: rtl/imm_extend_core.sv
// Purely combinational single-beat extension: SEXT, ZEXT or SEXT shifted left by one.
// CONCAT is assembled by the enclosing unit. In that mode this block returns
// the SEXT result, and the unit ignores it.
module imm_extend_core
  import imm_extend_unit_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] data_o
);

  logic [OUT_W-1:0] sext_w;
  logic [OUT_W-1:0] zext_w;
  mode_e            mode_w;

  assign mode_w = mode_e'(mode_i);
  assign sext_w = {{(OUT_W-IN_W){data_i[IN_W-1]}}, data_i};
  assign zext_w = {{(OUT_W-IN_W){1'b0}}, data_i};

  // Select the extension result. The shift drops the MSB of the sign-extended word.
  always_comb begin
    data_o = sext_w;
    case (mode_w)
      MODE_ZEXT:      data_o = zext_w;
      MODE_SEXT_SHL1: data_o = {sext_w[OUT_W-2:0], 1'b0};
      default:        data_o = sext_w;
    endcase
  end

endmodule : imm_extend_core

// File: rtl/imm_extend_unit.sv
// Immediate extension unit. It has a valid/ready input and a one-entry registered output.
// Single-beat modes produce a word one cycle after they are accepted.
// CONCAT takes two beats: the upper part comes first and the lower part second.
// The legal parameter range is IN_W < OUT_W <= 2*IN_W.
module imm_extend_unit
  import imm_extend_unit_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             hi_pending
);

  localparam int HI_W = OUT_W - IN_W;

  state_e           state_q;
  logic [HI_W-1:0]  hi_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic             hi_pending_q;
  logic [OUT_W-1:0] ext_d;
  logic             accept;
  mode_e            mode_w;

  assign mode_w = mode_e'(in_mode);

  // The output slot is free when it is empty or is draining this edge. Flush blocks any accept.
  assign in_ready = (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .data_i (in_data),
    .mode_i (in_mode),
    .data_o (ext_d)
  );

  // Control FSM with output register. Flush has priority over all other events.
  // Reset also clears the held upper part.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hi_q         <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      hi_pending_q <= 1'b0;
    end else if (flush) begin
      state_q      <= ST_IDLE;
      hi_q         <= '0;
      out_valid_q  <= 1'b0;
      hi_pending_q <= 1'b0;
    end else if (accept) begin
      if (state_q == ST_HI_HELD) begin
        // The second beat is always the lower part, whatever its mode.
        out_data_q   <= {hi_q, in_data};
        out_valid_q  <= 1'b1;
        state_q      <= ST_IDLE;
        hi_pending_q <= 1'b0;
      end else if (mode_w == MODE_CONCAT) begin
        // The upper beat produces no word. The slot is free or draining this edge, so it empties.
        hi_q         <= in_data[HI_W-1:0];
        out_valid_q  <= 1'b0;
        state_q      <= ST_HI_HELD;
        hi_pending_q <= 1'b1;
      end else begin
        out_data_q  <= ext_d;
        out_valid_q <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign hi_pending = hi_pending_q;

endmodule : imm_extend_unit

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit (IN_W=8, OUT_W=16).
// Inputs are driven and outputs are sampled on the falling edge.
module tb_imm_extend_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        hi_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_extend_unit #(.IN_W(8), .OUT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .hi_pending (hi_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Drive one beat, let one rising edge pass, and return at the next falling edge.
  task automatic beat(input logic v, input logic [7:0] d, input logic [1:0] m);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_hi_pending", hi_pending, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Single-beat modes with the consumer always ready
    beat(1, 8'h80, 2'b00); chk("sext80_v", out_valid, 1); chk("sext80_d", out_data, 16'hFF80);
    beat(1, 8'h7F, 2'b00); chk("sext7f_d", out_data, 16'h007F);
    beat(1, 8'hC0, 2'b01); chk("zextc0_d", out_data, 16'h00C0);
    beat(1, 8'hC0, 2'b10); chk("shl1c0_d", out_data, 16'hFF80);
    beat(1, 8'h40, 2'b10); chk("shl140_d", out_data, 16'h0080);

    // CONCAT: the upper beat empties the slot, and the lower beat ignores its own mode
    beat(1, 8'h12, 2'b11);
    chk("cat_hi_pending", hi_pending, 1);
    chk("cat_first_no_out", out_valid, 0);
    beat(1, 8'h34, 2'b00);
    chk("cat_v", out_valid, 1);
    chk("cat_d", out_data, 16'h1234);
    chk("cat_hi_clear", hi_pending, 0);

    // Output drains and nothing new arrives
    beat(0, 8'h00, 2'b00);
    chk("drain_v", out_valid, 0);

    // Backpressure: hold 0xFF80 for 5 cycles while 0x05 ZEXT waits
    out_ready = 1'b0;
    beat(1, 8'h80, 2'b00);
    chk("bp_load_d", out_data, 16'hFF80);
    in_data = 8'h05; in_mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); @(negedge clk);
      chk("bp_hold_v", out_valid, 1);
      chk("bp_hold_d", out_data, 16'hFF80);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); @(negedge clk);
    chk("bp_reload_v", out_valid, 1);
    chk("bp_reload_d", out_data, 16'h0005);

    // Reset pulse in the middle of a CONCAT
    beat(1, 8'hAB, 2'b11);
    chk("rstmid_hi_pending", hi_pending, 1);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_v", out_valid, 0);
    chk("rstmid_hp", hi_pending, 0);
    chk("rstmid_d", out_data, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    beat(1, 8'h01, 2'b01);
    chk("after_rst_d", out_data, 16'h0001);
    chk("after_rst_hp", hi_pending, 0);

    // Flush while the upper part is held, with a beat offered
    beat(1, 8'h55, 2'b11);
    chk("fl_hp_before", hi_pending, 1);
    flush = 1'b1;
    in_valid = 1'b1; in_data = 8'h34; in_mode = 2'b00;
    #1;
    chk("fl_in_ready", in_ready, 0);
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    chk("fl_hp", hi_pending, 0);
    chk("fl_v", out_valid, 0);

    // Flush while a word is held under backpressure
    out_ready = 1'b0;
    beat(1, 8'h7F, 2'b01);
    chk("fl2_loaded", out_valid, 1);
    flush = 1'b1;
    beat(1, 8'h22, 2'b00);
    flush = 1'b0;
    chk("fl2_v", out_valid, 0);
    out_ready = 1'b1;

    // After the flush the held upper part is gone, so this beat is plain SEXT
    beat(1, 8'h34, 2'b00);
    chk("post_fl_d", out_data, 16'h0034);
    beat(0, 8'h00, 2'b00);
    chk("final_drain", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_imm_extend_unit
